// File: rtl/dmem_ctrl.sv
// Data-memory controller: two-port round-robin arbiter in front of a
// single-port word memory, with read-modify-write for sub-word stores and
// RV32I load alignment/extension.
module dmem_ctrl #(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [2:0]            a_funct3,
   input  logic [31:0]           a_addr,
   input  logic [31:0]           a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [31:0]           a_rdata,
   output logic                  a_err,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [2:0]            b_funct3,
   input  logic [31:0]           b_addr,
   input  logic [31:0]           b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [31:0]           b_rdata,
   output logic                  b_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  mem_we,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   localparam int unsigned WIDX_W = ADDR_WIDTH - 2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_ptr_b;      // 1: B wins the next tie
   logic              r_own_b;
   logic              r_we;
   logic [2:0]        r_f3;
   logic [1:0]        r_lane;
   logic [WIDX_W-1:0] r_widx;
   logic [15:0]       r_wdata;
   logic              r_a_rvalid, r_b_rvalid, r_a_err, r_b_err;
   logic [31:0]       r_a_rdata, r_b_rdata;

   logic              w_sel_b, w_we, w_bad, w_grant;
   logic [2:0]        w_f3;
   logic [31:0]       w_addr, w_wdata;
   logic              w_resp, w_resp_b, w_resp_err;
   logic [31:0]       w_resp_data, w_ext, w_merged;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic              w_unused;

   assign w_unused = ^{a_addr[31:ADDR_WIDTH], b_addr[31:ADDR_WIDTH]};

   // Illegal funct3 for the direction, or address not aligned to the size
   function automatic logic f_bad(input logic we, input logic [2:0] f3,
                                  input logic [1:0] lo);
      logic ill;
      logic mis;
      if (we) ill = !(f3 inside {3'b000, 3'b001, 3'b010});
      else    ill = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      mis = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
      return ill || mis;
   endfunction

   // Round-robin selection and request field mux
   always_comb begin
      w_sel_b = b_req && (!a_req || r_ptr_b);
      w_we    = w_sel_b ? b_we     : a_we;
      w_f3    = w_sel_b ? b_funct3 : a_funct3;
      w_addr  = w_sel_b ? b_addr   : a_addr;
      w_wdata = w_sel_b ? b_wdata  : a_wdata;
      w_bad   = f_bad(w_we, w_f3, w_addr[1:0]);
   end

   // Lane extraction, load extension and sub-word store merge
   always_comb begin
      w_byte   = 8'h00;
      w_merged = mem_rdata;
      case (r_lane)
         2'd0: begin w_byte = mem_rdata[7:0];   w_merged[7:0]   = r_wdata[7:0]; end
         2'd1: begin w_byte = mem_rdata[15:8];  w_merged[15:8]  = r_wdata[7:0]; end
         2'd2: begin w_byte = mem_rdata[23:16]; w_merged[23:16] = r_wdata[7:0]; end
         default: begin w_byte = mem_rdata[31:24]; w_merged[31:24] = r_wdata[7:0]; end
      endcase
      w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      if (r_f3[1:0] == 2'b01) begin
         w_merged = r_lane[1] ? {r_wdata, mem_rdata[15:0]} : {mem_rdata[31:16], r_wdata};
      end
      case (r_f3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'h000000, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'h0000, w_half};
         default: w_ext = mem_rdata;
      endcase
   end

   // Next state, grants and memory strobes; all forced low while in reset
   always_comb begin
      w_state_nxt = r_state;
      a_gnt       = 1'b0;
      b_gnt       = 1'b0;
      mem_re      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      w_grant     = 1'b0;
      w_resp      = 1'b0;
      w_resp_b    = 1'b0;
      w_resp_err  = 1'b0;
      w_resp_data = '0;
      case (r_state)
         S_IDLE: begin
            if (a_req || b_req) begin
               w_grant  = 1'b1;
               a_gnt    = !w_sel_b;
               b_gnt    = w_sel_b;
               w_resp_b = w_sel_b;
               if (w_bad) begin
                  w_resp      = 1'b1;
                  w_resp_err  = 1'b1;
                  w_state_nxt = S_RESP;
               end else if (w_we && (w_f3 == 3'b010)) begin
                  mem_we      = 1'b1;
                  mem_addr    = {w_addr[ADDR_WIDTH-1:2], 2'b00};
                  mem_wdata   = w_wdata;
                  w_resp      = 1'b1;
                  w_state_nxt = S_RESP;
               end else begin
                  mem_re      = 1'b1;
                  mem_addr    = {w_addr[ADDR_WIDTH-1:2], 2'b00};
                  w_state_nxt = S_RD;
               end
            end
         end
         S_RD: begin
            w_resp      = 1'b1;
            w_resp_b    = r_own_b;
            w_state_nxt = S_RESP;
            if (r_we) begin
               mem_we    = 1'b1;
               mem_addr  = {r_widx, 2'b00};
               mem_wdata = w_merged;
            end else begin
               w_resp_data = w_ext;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (!rst_n) begin
         a_gnt     = 1'b0;
         b_gnt     = 1'b0;
         mem_re    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Captured request, arbitration pointer and registered responses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr_b    <= 1'b0;
         r_own_b    <= 1'b0;
         r_we       <= 1'b0;
         r_f3       <= 3'b000;
         r_lane     <= 2'b00;
         r_widx     <= '0;
         r_wdata    <= 16'h0000;
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_err    <= 1'b0;
         r_b_err    <= 1'b0;
         r_a_rdata  <= '0;
         r_b_rdata  <= '0;
      end else begin
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
         r_a_err    <= 1'b0;
         r_b_err    <= 1'b0;
         if (w_grant) begin
            r_ptr_b <= !w_sel_b;
            r_own_b <= w_sel_b;
            r_we    <= w_we;
            r_f3    <= w_f3;
            r_lane  <= w_addr[1:0];
            r_widx  <= w_addr[ADDR_WIDTH-1:2];
            r_wdata <= w_wdata[15:0];
         end
         if (w_resp) begin
            if (w_resp_b) begin
               r_b_rvalid <= 1'b1;
               r_b_err    <= w_resp_err;
               r_b_rdata  <= w_resp_data;
            end else begin
               r_a_rvalid <= 1'b1;
               r_a_err    <= w_resp_err;
               r_a_rdata  <= w_resp_data;
            end
         end
      end
   end

   assign a_rvalid = r_a_rvalid;
   assign b_rvalid = r_b_rvalid;
   assign a_err    = r_a_err;
   assign b_err    = r_b_err;
   assign a_rdata  = r_a_rdata;
   assign b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed requests on both ports, expected responses
// queued at grant time and checked by an independent response monitor.
module tb_dmem_ctrl;

   localparam int unsigned AW = 12;

   logic clk = 1'b0;
   logic rst_n;
   logic a_req, a_we, b_req, b_we;
   logic [2:0] a_funct3, b_funct3;
   logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
   logic a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
   logic [31:0] a_rdata, b_rdata;
   logic [AW-1:0] mem_addr;
   logic mem_re, mem_we;
   logic [31:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_WIDTH(AW)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_funct3(a_funct3), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_we(b_we), .b_funct3(b_funct3), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Single-port word memory, read data one cycle after mem_re
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[AW-1:2]] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr[AW-1:2]];
   end

   typedef struct { bit port_b; logic [31:0] data; bit err; int due; } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;
   int n_vec = 0;
   int n_fail = 0;
   int cyc = 0;
   int strobes = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Response monitor: every rvalid pops and checks the oldest expectation
   always @(negedge clk) begin
      if ((a_err && !a_rvalid) || (b_err && !b_rvalid)) begin
         n_fail++;
         $display("FAIL err_without_rvalid a_err=%0b b_err=%0b required 0", a_err, b_err);
      end
      if (a_rvalid || b_rvalid) begin
         n_vec++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid a=%0b b=%0b required none", a_rvalid, b_rvalid);
         end else begin
            mon_e = sb_q.pop_front();
            if (a_rvalid != !mon_e.port_b || b_rvalid != mon_e.port_b ||
                (mon_e.port_b ? b_rdata : a_rdata) != mon_e.data ||
                (mon_e.port_b ? b_err : a_err) != mon_e.err || cyc != mon_e.due) begin
               n_fail++;
               $display("FAIL rsp a_rv=%0b b_rv=%0b data=%h err=%0b cyc=%0d required port_b=%0b data=%h err=%0b cyc=%0d",
                        a_rvalid, b_rvalid, mon_e.port_b ? b_rdata : a_rdata,
                        mon_e.port_b ? b_err : a_err, cyc,
                        mon_e.port_b, mon_e.data, mon_e.err, mon_e.due);
            end
         end
      end
   end

   // Memory-strobe sanity, sampled mid-cycle
   initial forever begin
      @(negedge clk);
      #3;
      if (mem_re || mem_we) strobes++;
      if (mem_re && mem_we) begin
         n_fail++;
         $display("FAIL strobe_overlap re=1 we=1 required exclusive");
      end
      if (!mem_we && mem_wdata != 32'h0) begin
         n_fail++;
         $display("FAIL idle_wdata got %h required 0", mem_wdata);
      end
      if (!mem_re && !mem_we && mem_addr != '0) begin
         n_fail++;
         $display("FAIL idle_addr got %h required 0", mem_addr);
      end
   end

   task automatic set_port(input bit pb, input bit req, input bit we,
                           input logic [2:0] f3, input logic [31:0] addr, wd);
      if (pb) begin b_req = req; b_we = we; b_funct3 = f3; b_addr = addr; b_wdata = wd; end
      else    begin a_req = req; a_we = we; a_funct3 = f3; a_addr = addr; a_wdata = wd; end
   endtask

   task automatic check_zero(input string name);
      n_vec++;
      if (a_gnt || b_gnt || a_rvalid || b_rvalid || a_err || b_err || a_rdata != 0 ||
          b_rdata != 0 || mem_re || mem_we || mem_addr != '0 || mem_wdata != 0) begin
         n_fail++;
         $display("FAIL %s outputs gnt=%0b%0b rv=%0b%0b err=%0b%0b rd=%h/%h re=%0b we=%0b ma=%h wd=%h required all 0",
                  name, a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err, a_rdata, b_rdata,
                  mem_re, mem_we, mem_addr, mem_wdata);
      end
   endtask

   // Issue one request, check the grant-cycle strobes and queue the response
   task automatic do_req(input string name, input bit pb, input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, wd, exp_d, input bit exp_err, input int lat);
      bit got;
      int t0;
      int s0;
      bit exp_re;
      bit exp_we;
      logic [AW-1:0] exp_ma;
      got = 1'b0;
      @(negedge clk);
      set_port(pb, 1'b1, we, f3, addr, wd);
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (pb ? b_gnt : a_gnt) got = 1'b1;
         else @(negedge clk);
      end
      n_vec++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s grant never seen required within 20 cycles", name);
         set_port(pb, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
         return;
      end
      t0 = cyc;
      s0 = strobes;
      sb_q.push_back('{pb, exp_d, exp_err, t0 + lat});
      exp_we = !exp_err && we && (f3 == 3'b010);
      exp_re = !exp_err && !exp_we;
      exp_ma = (exp_re || exp_we) ? {addr[AW-1:2], 2'b00} : '0;
      if (mem_re != exp_re || mem_we != exp_we || mem_addr != exp_ma ||
          (exp_we && mem_wdata != wd) || (pb ? a_gnt : b_gnt)) begin
         n_fail++;
         $display("FAIL %s grant_cycle re=%0b we=%0b ma=%h wd=%h other_gnt=%0b required re=%0b we=%0b ma=%h wd=%h other_gnt=0",
                  name, mem_re, mem_we, mem_addr, mem_wdata, pb ? a_gnt : b_gnt,
                  exp_re, exp_we, exp_ma, exp_we ? wd : mem_wdata);
      end
      @(negedge clk);
      set_port(pb, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      if (exp_err) begin
         #4;
         n_vec++;
         if (strobes != s0) begin
            n_fail++;
            $display("FAIL %s err_strobes got %0d required 0", name, strobes - s0);
         end
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      n_vec++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain pending=%0d required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   logic [31:0] v_word;
   int t_prev;
   bit exp_b;

   initial begin
      rst_n = 1'b0;
      set_port(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      set_port(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      #1 check_zero("reset_initial");
      @(negedge clk);
      rst_n = 1'b1;

      // Word store then load
      do_req("sw_10",   0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
      do_req("lw_10",   0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
      // Byte store with read-modify-write, then the load variants
      do_req("sb_11",   0, 1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 0, 2);
      do_req("lb_11",   0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 2);
      do_req("lbu_11",  0, 0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 0, 2);
      do_req("lh_12",   0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 2);
      do_req("lhu_12",  0, 0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0, 2);
      do_req("lw_10b",  0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 0, 2);
      // Port B traffic, lower-half and top-byte merges, aliasing above ADDR_WIDTH
      do_req("b_sw_20", 1, 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, 1);
      do_req("b_sh_20", 1, 1, 3'b001, 32'h20, 32'hFFFF8055, 32'h0, 0, 2);
      do_req("b_lh_20", 1, 0, 3'b001, 32'h20, 32'h0, 32'hFFFF8055, 0, 2);
      do_req("b_lbu_23",1, 0, 3'b100, 32'h23, 32'h0, 32'h00000011, 0, 2);
      do_req("b_lbu_22",1, 0, 3'b100, 32'h22, 32'h0, 32'h00000022, 0, 2);
      do_req("b_sb_23", 1, 1, 3'b000, 32'h23, 32'h00000099, 32'h0, 0, 2);
      do_req("b_lw_1020",1,0, 3'b010, 32'h1020, 32'h0, 32'h99228055, 0, 2);
      // Errors: misaligned and illegal funct3
      do_req("e_lw_13", 0, 0, 3'b010, 32'h13, 32'h0, 32'h0, 1, 1);
      do_req("e_ld_011",0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1);
      do_req("e_sh_11", 0, 1, 3'b001, 32'h11, 32'h1234, 32'h0, 1, 1);
      do_req("e_st_100",0, 1, 3'b100, 32'h10, 32'h55, 32'h0, 1, 1);
      do_req("e_lh_11", 0, 0, 3'b001, 32'h11, 32'h0, 32'h0, 1, 1);
      do_req("e_b_lhu13",1,0, 3'b101, 32'h13, 32'h0, 32'h0, 1, 1);
      drain("pre_abort");

      // Reset while a halfword store sits in RD
      @(negedge clk);
      set_port(1'b0, 1'b1, 1'b1, 3'b001, 32'h12, 32'h00005555);
      #1;
      n_vec++;
      if (!a_gnt || !mem_re) begin
         n_fail++;
         $display("FAIL abort_sh_grant gnt=%0b re=%0b required 1 1", a_gnt, mem_re);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1 check_zero("reset_in_rd");
      @(negedge clk);
      #1 check_zero("reset_hold");
      n_vec++;
      v_word = mem[4];
      if (v_word != 32'hDEADAAEF && v_word != 32'h5555AAEF) begin
         n_fail++;
         $display("FAIL abort_mem got %h required DEADAAEF or 5555AAEF", v_word);
      end
      set_port(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      do_req("post_b_lw", 1, 0, 3'b010, 32'h10, 32'h0, v_word, 0, 2);
      do_req("post_a_lw", 0, 0, 3'b010, 32'h20, 32'h0, 32'h99228055, 0, 2);
      drain("pre_contend");

      // Contention from reset: both ports hold LW, grants alternate A,B,A,B
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_port(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      set_port(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
      #1;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         int w;
         w = 0;
         while (!(a_gnt || b_gnt) && w < 10) begin
            @(negedge clk);
            #1;
            w++;
         end
         exp_b = (k % 2) == 1;
         n_vec++;
         if (w >= 10) begin
            n_fail++;
            $display("FAIL contend_%0d no grant required within 10 cycles", k);
            break;
         end
         if (a_gnt != !exp_b || b_gnt != exp_b || (k > 0 && cyc - t_prev != 3)) begin
            n_fail++;
            $display("FAIL contend_%0d gnt a=%0b b=%0b gap=%0d required a=%0b b=%0b gap=3",
                     k, a_gnt, b_gnt, cyc - t_prev, !exp_b, exp_b);
         end
         sb_q.push_back('{b_gnt, b_gnt ? 32'h99228055 : v_word, 1'b0, cyc + 2});
         t_prev = cyc;
         @(negedge clk);
         #1;
      end
      set_port(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      set_port(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      drain("final");
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
